// File: rtl/xge_wb_master.sv
// Command-to-Wishbone bridge: accepts one register command at a time, runs a
// single Wishbone classic cycle with a bounded wait for ack, and returns a
// response (read data or timeout error) under a valid/ready handshake.
module xge_wb_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [7:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [7:0]  err_count,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [7:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter value of the last BUS cycle that may still wait for an ack.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_reg, state_next;
    logic        cmd_ready_reg, cmd_ready_next;
    logic        cyc_reg, cyc_next;
    logic        stb_reg, stb_next;
    logic        we_reg, we_next;
    logic [7:0]  adr_reg, adr_next;
    logic [31:0] dat_reg, dat_next;
    logic        rsp_valid_reg, rsp_valid_next;
    logic [31:0] rsp_rdata_reg, rsp_rdata_next;
    logic        rsp_err_reg, rsp_err_next;
    logic [7:0]  err_count_reg, err_count_next;
    logic [7:0]  to_cnt_reg, to_cnt_next;

    // Next-state and next-output logic; every output is computed here and
    // registered below so nothing combinational reaches a port.
    always_comb begin
        state_next     = state_reg;
        cmd_ready_next = cmd_ready_reg;
        cyc_next       = cyc_reg;
        stb_next       = stb_reg;
        we_next        = we_reg;
        adr_next       = adr_reg;
        dat_next       = dat_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;
        err_count_next = err_count_reg;
        to_cnt_next    = to_cnt_reg;

        case (state_reg)
            IDLE: begin
                // cmd_ready is low for the first cycle after reset release,
                // so a command is only taken once the handshake is advertised.
                cmd_ready_next = 1'b1;
                if (cmd_ready_reg && cmd_valid) begin
                    state_next     = BUS;
                    cmd_ready_next = 1'b0;
                    cyc_next       = 1'b1;
                    stb_next       = 1'b1;
                    we_next        = cmd_we;
                    adr_next       = cmd_addr;
                    dat_next       = cmd_we ? cmd_wdata : 32'h0;
                    to_cnt_next    = 8'h0;
                end
            end

            BUS: begin
                // Ack wins over a simultaneous timeout.
                if (wb_ack_i) begin
                    state_next     = RESP;
                    cyc_next       = 1'b0;
                    stb_next       = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_rdata_next = we_reg ? 32'h0 : wb_dat_i;
                    rsp_err_next   = 1'b0;
                end else if (to_cnt_reg == TIMEOUT_LAST) begin
                    state_next     = RESP;
                    cyc_next       = 1'b0;
                    stb_next       = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_rdata_next = 32'h0;
                    rsp_err_next   = 1'b1;
                    if (err_count_reg != 8'hFF) begin
                        err_count_next = err_count_reg + 8'h1;
                    end
                end else begin
                    to_cnt_next = to_cnt_reg + 8'h1;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    state_next     = IDLE;
                    rsp_valid_next = 1'b0;
                    cmd_ready_next = 1'b1;
                end
            end

            default: begin
                state_next     = IDLE;
                cmd_ready_next = 1'b0;
                cyc_next       = 1'b0;
                stb_next       = 1'b0;
                rsp_valid_next = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset; reset also aborts
    // any cycle in flight without producing a response.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg     <= IDLE;
            cmd_ready_reg <= 1'b0;
            cyc_reg       <= 1'b0;
            stb_reg       <= 1'b0;
            we_reg        <= 1'b0;
            adr_reg       <= 8'h0;
            dat_reg       <= 32'h0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 32'h0;
            rsp_err_reg   <= 1'b0;
            err_count_reg <= 8'h0;
            to_cnt_reg    <= 8'h0;
        end else begin
            state_reg     <= state_next;
            cmd_ready_reg <= cmd_ready_next;
            cyc_reg       <= cyc_next;
            stb_reg       <= stb_next;
            we_reg        <= we_next;
            adr_reg       <= adr_next;
            dat_reg       <= dat_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
            err_count_reg <= err_count_next;
            to_cnt_reg    <= to_cnt_next;
        end
    end

    assign cmd_ready = cmd_ready_reg;
    assign wb_cyc_o  = cyc_reg;
    assign wb_stb_o  = stb_reg;
    assign wb_we_o   = we_reg;
    assign wb_adr_o  = adr_reg;
    assign wb_dat_o  = dat_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;
    assign err_count = err_count_reg;

endmodule
